brick_scan_controller: RTL and testbench
========================================

// Module: brick_scan_controller
// PURPOSE
//  Owns the 5x12 brick grid state for the breakout game and sequences brick-vs-ball collision checks.
//  On each game-tick request it walks the grid one brick per clock (fastClk domain), marks hit bricks and reports hits.
//  It asserts one bounce request per scan and keeps the remaining-brick count.
//  Sits between the game FSM (which issues scan_start and consumes bounce_y/hit_valid) and the VGA renderer (which reads the hit map).
// PARAMETERS
//  ROWS     5    brick rows
//  COLS     12   brick columns
//  LEFT_X   250  hCount of the grid's left edge
//  TOP_Y    35   vCount of the grid's top edge
//  BRICK_W  45   brick width in px
//  BRICK_H  25   brick height in px
//  BALL_R   5    ball half-size in px
// PORTS
//  clk          in   1   scan clock (fast clock); one clock only
//  rst          in   1   asynchronous, active-high reset
//  scan_start   in   1   request a grid scan; sampled only in IDLE
//  ball_x       in   10  ball centre x; latched at scan_start
//  ball_y       in   10  ball centre y; latched at scan_start
//  clear_grid   in   1   restore all bricks (new game/level)
//  qry_row      in   3   renderer query row
//  qry_col      in   4   renderer query column
//  qry_hit      out  1   combinational: brick (qry_row,qry_col) is destroyed
//  busy         out  1   high in SCAN and DONE
//  hit_valid    out  1   1-cycle pulse; brick hit_row/hit_col was destroyed
//  hit_row      out  3   row of last hit
//  hit_col      out  4   column of last hit
//  scan_done    out  1   1-cycle pulse ending a scan
//  bounce_y     out  1   1-cycle pulse with scan_done if the scan hit at least one brick
//  bricks_left  out  6   live brick count
//  all_cleared  out  1   bricks_left == 0
// BEHAVIOUR
//  Reset: state IDLE; all bricks live; bricks_left = ROWS*COLS (60); every other registered output = 0.
//  FSM: IDLE -> SCAN on scan_start; SCAN -> DONE after the last brick or on the first hit (see CONFIGURATION); DONE -> IDLE after 1 cycle.
//  Scan order: row-major, index k = row*COLS + col, from 0 to 59. Brick k is evaluated in cycle k+1 after the start edge (cycle 0).
//  Brick origin: bx = LEFT_X + col*BRICK_W, by = TOP_Y + row*BRICK_H.
//  Overlap test (inclusive, 11-bit unsigned, no subtraction, so no underflow):
//   ball_x+BALL_R >= bx && ball_x <= bx+BRICK_W+BALL_R && ball_y+BALL_R >= by && ball_y <= by+BRICK_H+BALL_R.
//  Already-destroyed bricks never hit. On a hit: clear the live bit, decrement bricks_left,
//   register hit_row/hit_col, and pulse hit_valid in the cycle after evaluation.
//  scan_done and bounce_y are asserted in the DONE cycle. A no-hit full scan gives scan_done at cycle 61.
//  scan_start while busy: ignored, not queued. ball_x/ball_y changes during a scan: ignored (latched copy used).
//  clear_grid: highest priority. It restores all bricks and sets bricks_left=60. If busy, the scan aborts to IDLE with no scan_done/bounce_y.
//   Simultaneous clear_grid and scan_start in IDLE: clear wins and the start is dropped.
//  qry_* out of range (row>=ROWS or col>=COLS): qry_hit = 1.
//  Reset mid-scan: immediate return to reset values.
// CONFIGURATION
//  MULTI_HIT_EN defined: the scan always visits all 60 bricks. Every overlapping live brick is destroyed, with one hit_valid pulse each.
//   bounce_y still pulses only once per scan.
//  MULTI_HIT_EN undefined: the first hit ends the scan. DONE follows immediately, so hit_valid and scan_done coincide.
// STRUCTURE
//  breakout_pkg: grid geometry localparams (ROWS, COLS, LEFT_X, TOP_Y, BRICK_W, BRICK_H, BALL_R) and FSM state encodings.
//   Shared with block_controller and the renderer.
//  Sub-module brick_overlap: combinational box test (ball_x, ball_y, bx, by) -> overlap.
//  Top level holds the FSM, row/col counters, 60-bit live map and bricks_left counter.
// TESTING
//  1. Reset, then scan_start with ball (480,300) -> no hit_valid; scan_done at cycle 61; bricks_left=60.
//  2. Ball (405,97) -> hit_valid with row2/col3; bricks_left=59; bounce_y with scan_done; qry(2,3)=1. Repeat the scan -> no hit.
//  3. Ball (430,110), MULTI_HIT_EN off -> single hit (2,3) and early scan_done.
//     MULTI_HIT_EN on -> hits (2,3),(2,4),(3,3),(3,4); bricks_left=56; one bounce_y.
//  4. Pulse clear_grid at scan cycle 20 -> scan aborts, no scan_done; bricks_left=60; qry(2,3)=0.
//  5. scan_start pulsed during a scan -> ignored; exactly one scan_done. Start and clear together in IDLE -> busy stays 0.
//  6. Destroy all 60 bricks via directed positions -> all_cleared=1. qry(5,0) and qry(0,12) return 1.

Source files
------------

// File: rtl/breakout_pkg.sv
// Breakout grid geometry and brick-scan FSM encoding, shared by the scan
// controller, the block controller and the renderer.
package breakout_pkg;

  localparam int unsigned ROWS    = 5;
  localparam int unsigned COLS    = 12;
  localparam int unsigned LEFT_X  = 250;
  localparam int unsigned TOP_Y   = 35;
  localparam int unsigned BRICK_W = 45;
  localparam int unsigned BRICK_H = 25;
  localparam int unsigned BALL_R  = 5;
  localparam int unsigned NBRICKS = ROWS * COLS;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } scan_state_e;

  // Pixel x of the left edge of brick column col.
  function automatic logic [10:0] brick_x(input logic [3:0] col);
    return 11'(LEFT_X) + 11'(col) * 11'(BRICK_W);
  endfunction

  // Pixel y of the top edge of brick row row.
  function automatic logic [10:0] brick_y(input logic [2:0] row);
    return 11'(TOP_Y) + 11'(row) * 11'(BRICK_H);
  endfunction

endpackage

// File: rtl/brick_overlap.sv
// Combinational ball-vs-brick box test. All terms are compared additively in
// 11 bits so nothing can underflow near the screen origin.
module brick_overlap
  import breakout_pkg::*;
(
  input  logic [9:0]  ball_x_i,
  input  logic [9:0]  ball_y_i,
  input  logic [10:0] bx_i,
  input  logic [10:0] by_i,
  output logic        overlap_o
);

  logic [10:0] ball_x_w;
  logic [10:0] ball_y_w;

  assign ball_x_w = {1'b0, ball_x_i};
  assign ball_y_w = {1'b0, ball_y_i};

  // Inclusive overlap of the ball's box with the brick's box.
  always_comb begin
    overlap_o = (ball_x_w + 11'(BALL_R) >= bx_i) &&
                (ball_x_w <= bx_i + 11'(BRICK_W + BALL_R)) &&
                (ball_y_w + 11'(BALL_R) >= by_i) &&
                (ball_y_w <= by_i + 11'(BRICK_H + BALL_R));
  end

endmodule

// File: rtl/brick_scan_controller.sv
// Brick grid owner for breakout: keeps the live map and count, and on
// scan_start walks all bricks one per clock testing them against the ball.
// Optional feature macro: MULTI_HIT_EN (defined: every overlapping brick in a
// scan is destroyed; undefined: the first hit ends the scan).
module brick_scan_controller
  import breakout_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_start,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic       clear_grid,
  input  logic [2:0] qry_row,
  input  logic [3:0] qry_col,
  output logic       qry_hit,
  output logic       busy,
  output logic       hit_valid,
  output logic [2:0] hit_row,
  output logic [3:0] hit_col,
  output logic       scan_done,
  output logic       bounce_y,
  output logic [5:0] bricks_left,
  output logic       all_cleared
);

  scan_state_e        state_q, state_d;
  logic [2:0]         row_q, row_d;
  logic [3:0]         col_q, col_d;
  logic [9:0]         ball_x_q, ball_x_d;
  logic [9:0]         ball_y_q, ball_y_d;
  logic [NBRICKS-1:0] live_q, live_d;
  logic [5:0]         left_q, left_d;
  logic               hit_valid_q, hit_valid_d;
  logic [2:0]         hit_row_q, hit_row_d;
  logic [3:0]         hit_col_q, hit_col_d;
  logic               any_hit_q, any_hit_d;

  logic [5:0] brick_idx;
  logic       overlap_w;
  logic       hit_w;
  logic       last_w;
  logic       end_scan_w;
  logic [6:0] qry_idx;

  assign brick_idx = 6'(row_q) * 6'(COLS) + 6'(col_q);
  assign last_w    = (row_q == 3'(ROWS - 1)) && (col_q == 4'(COLS - 1));

  brick_overlap u_overlap (
    .ball_x_i  (ball_x_q),
    .ball_y_i  (ball_y_q),
    .bx_i      (brick_x(col_q)),
    .by_i      (brick_y(row_q)),
    .overlap_o (overlap_w)
  );

  assign hit_w = (state_q == StScan) && overlap_w && live_q[brick_idx];

`ifdef MULTI_HIT_EN
  assign end_scan_w = last_w;
`else
  assign end_scan_w = last_w || hit_w;
`endif

  // Next-state for the FSM, scan counters, live map and hit reporting.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    live_d      = live_q;
    left_d      = left_q;
    hit_valid_d = 1'b0;
    hit_row_d   = hit_row_q;
    hit_col_d   = hit_col_q;
    any_hit_d   = any_hit_q;

    if (clear_grid) begin
      // Clear outranks everything, including a hit found this cycle.
      state_d   = StIdle;
      row_d     = '0;
      col_d     = '0;
      live_d    = '1;
      left_d    = 6'(NBRICKS);
      any_hit_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (scan_start) begin
            state_d   = StScan;
            row_d     = '0;
            col_d     = '0;
            ball_x_d  = ball_x;
            ball_y_d  = ball_y;
            any_hit_d = 1'b0;
          end
        end
        StScan: begin
          if (hit_w) begin
            live_d[brick_idx] = 1'b0;
            left_d            = left_q - 6'd1;
            hit_valid_d       = 1'b1;
            hit_row_d         = row_q;
            hit_col_d         = col_q;
            any_hit_d         = 1'b1;
          end
          if (end_scan_w) begin
            state_d = StDone;
          end else if (col_q == 4'(COLS - 1)) begin
            col_d = '0;
            row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 4'd1;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers; reset restores a full grid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      ball_x_q    <= '0;
      ball_y_q    <= '0;
      live_q      <= '1;
      left_q      <= 6'(NBRICKS);
      hit_valid_q <= 1'b0;
      hit_row_q   <= '0;
      hit_col_q   <= '0;
      any_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      live_q      <= live_d;
      left_q      <= left_d;
      hit_valid_q <= hit_valid_d;
      hit_row_q   <= hit_row_d;
      hit_col_q   <= hit_col_d;
      any_hit_q   <= any_hit_d;
    end
  end

  assign qry_idx = 7'(qry_row) * 7'(COLS) + 7'(qry_col);

  // Output decode; a clear in the DONE cycle suppresses the completion pulses.
  always_comb begin
    busy        = (state_q != StIdle);
    scan_done   = (state_q == StDone) && !clear_grid;
    bounce_y    = scan_done && any_hit_q;
    hit_valid   = hit_valid_q;
    hit_row     = hit_row_q;
    hit_col     = hit_col_q;
    bricks_left = left_q;
    all_cleared = (left_q == 6'd0);
    // Out-of-range queries read as destroyed so the renderer draws nothing.
    if ((qry_row >= 3'(ROWS)) || (qry_col >= 4'(COLS))) begin
      qry_hit = 1'b1;
    end else begin
      qry_hit = !live_q[qry_idx[5:0]];
    end
  end

endmodule

// File: tb/tb_brick_scan_controller.sv
// Self-checking bench for brick_scan_controller: directed scenarios, a query
// table and randomized scans checked against a grid-level reference model.
module tb_brick_scan_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scan_start = 1'b0;
  logic [9:0] ball_x = '0;
  logic [9:0] ball_y = '0;
  logic       clear_grid = 1'b0;
  logic [2:0] qry_row = '0;
  logic [3:0] qry_col = '0;
  logic       qry_hit, busy, hit_valid, scan_done, bounce_y, all_cleared;
  logic [2:0] hit_row;
  logic [3:0] hit_col;
  logic [5:0] bricks_left;

  brick_scan_controller dut (
    .clk         (clk),
    .rst         (rst),
    .scan_start  (scan_start),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .clear_grid  (clear_grid),
    .qry_row     (qry_row),
    .qry_col     (qry_col),
    .qry_hit     (qry_hit),
    .busy        (busy),
    .hit_valid   (hit_valid),
    .hit_row     (hit_row),
    .hit_col     (hit_col),
    .scan_done   (scan_done),
    .bounce_y    (bounce_y),
    .bricks_left (bricks_left),
    .all_cleared (all_cleared)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Reference model: which bricks are alive, and how many.
  bit model_live[60];
  int model_left;

  typedef struct {
    logic [2:0] r;
    logic [3:0] c;
    logic       exp;
  } qvec_t;
  qvec_t qtab[$];

  task automatic check(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit ovl(input int x, input int y, input int r, input int c);
    int bx, by;
    bx = 250 + c * 45;
    by = 35 + r * 25;
    return (x + 5 >= bx) && (x <= bx + 50) && (y + 5 >= by) && (y <= by + 30);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 60; k++) model_live[k] = 1'b1;
    model_left = 60;
  endfunction

  function automatic bit model_qry(input int r, input int c);
    if (r >= 5 || c >= 12) return 1'b1;
    return !model_live[r * 12 + c];
  endfunction

  task automatic query(input int r, input int c, input string name);
    qry_row = 3'(r);
    qry_col = 4'(c);
    #1;
    check(name, int'(qry_hit), int'(model_qry(r, c)));
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_grid = 1'b1;
    @(negedge clk);
    clear_grid = 1'b0;
    model_reset();
    check("clear_left", int'(bricks_left), 60);
  endtask

  // One complete scan, checking every cycle from the start edge to DONE.
  task automatic run_scan(input int x, input int y);
    int hits[$];
    int done_e;
    bit exp_hv;
    int exp_k;
    for (int k = 0; k < 60; k++) begin
      if (model_live[k] && ovl(x, y, k / 12, k % 12)) begin
        hits.push_back(k);
`ifndef MULTI_HIT_EN
        break;
`endif
      end
    end
`ifdef MULTI_HIT_EN
    done_e = 60;
`else
    done_e = (hits.size() > 0) ? hits[0] + 1 : 60;
`endif
    @(negedge clk);
    scan_start = 1'b1;
    ball_x = 10'(x);
    ball_y = 10'(y);
    @(negedge clk);
    scan_start = 1'b0;
    check("busy_start", int'(busy), 1);
    for (int e = 1; e <= done_e; e++) begin
      @(negedge clk);
      if (e == 3) begin
        ball_x = 10'($urandom_range(0, 1023));
        ball_y = 10'($urandom_range(0, 1023));
      end
      exp_hv = 1'b0;
      exp_k  = 0;
      foreach (hits[i]) if (hits[i] == e - 1) begin
        exp_hv = 1'b1;
        exp_k  = hits[i];
      end
      check("hit_valid", int'(hit_valid), int'(exp_hv));
      if (exp_hv) begin
        check("hit_row", int'(hit_row), exp_k / 12);
        check("hit_col", int'(hit_col), exp_k % 12);
      end
      check("scan_done", int'(scan_done), int'(e == done_e));
      check("bounce_y", int'(bounce_y), int'(e == done_e && hits.size() > 0));
    end
    foreach (hits[i]) begin
      model_live[hits[i]] = 1'b0;
      model_left--;
    end
    @(negedge clk);
    check("busy_end", int'(busy), 0);
    check("bricks_left", int'(bricks_left), model_left);
    check("all_cleared", int'(all_cleared), int'(model_left == 0));
  endtask

  initial begin
    int n_done;
    model_reset();

    // Reset state
    #12;
    check("rst_left", int'(bricks_left), 60);
    check("rst_busy", int'(busy), 0);
    check("rst_hv", int'(hit_valid), 0);
    check("rst_done", int'(scan_done), 0);
    check("rst_row", int'(hit_row), 0);
    check("rst_clr", int'(all_cleared), 0);
    query(0, 0, "rst_qry");
    @(negedge clk);
    rst = 1'b0;

    // 1. No-hit full scan
    run_scan(480, 300);

    // 2. Single hit at (2,3), then the same ball again finds nothing
    run_scan(405, 97);
    qtab = '{'{3'd2, 4'd3, 1'b1}, '{3'd2, 4'd4, 1'b0}, '{3'd0, 4'd0, 1'b0},
             '{3'd5, 4'd0, 1'b1}, '{3'd0, 4'd12, 1'b1}, '{3'd7, 4'd15, 1'b1},
             '{3'd4, 4'd11, 1'b0}, '{3'd1, 4'd3, 1'b0}};
    foreach (qtab[i]) begin
      qry_row = qtab[i].r;
      qry_col = qtab[i].c;
      #1;
      check("qry_table", int'(qry_hit), int'(qtab[i].exp));
    end
    run_scan(405, 97);

    // 3. Four-brick corner ball
    do_clear();
    run_scan(430, 110);

    // 4. Clear mid-scan aborts without scan_done
    @(negedge clk);
    scan_start = 1'b1;
    ball_x = 10'd480;
    ball_y = 10'd300;
    @(negedge clk);
    scan_start = 1'b0;
    repeat (19) @(negedge clk);
    clear_grid = 1'b1;
    #1;
    check("abort_done", int'(scan_done), 0);
    @(negedge clk);
    clear_grid = 1'b0;
    model_reset();
    check("abort_busy", int'(busy), 0);
    check("abort_left", int'(bricks_left), 60);
    query(2, 3, "abort_qry");
    n_done = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (scan_done) n_done++;
    end
    check("abort_no_done", n_done, 0);

    // 5. Start during a scan is ignored; start+clear in idle is dropped
    @(negedge clk);
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    repeat (10) @(negedge clk);
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      if (scan_done) n_done++;
    end
    check("one_done", n_done, 1);
    @(negedge clk);
    scan_start = 1'b1;
    clear_grid = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    clear_grid = 1'b0;
    check("start_clr_busy", int'(busy), 0);
    @(negedge clk);
    check("start_clr_busy2", int'(busy), 0);

    // Randomized scans against the model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) do_clear();
      run_scan(int'($urandom_range(200, 850)), int'($urandom_range(0, 200)));
      query(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), "rand_qry");
    end

    // 6. Destroy every brick by aiming at each centre
    do_clear();
    for (int k = 0; k < 60; k++) run_scan(250 + (k % 12) * 45 + 22, 35 + (k / 12) * 25 + 12);
    check("all_cleared_final", int'(all_cleared), 1);
    query(5, 0, "qry_row_oob");
    query(0, 12, "qry_col_oob");
    query(3, 7, "qry_dead");

    // Asynchronous reset mid-scan restores the full grid at once
    @(negedge clk);
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    repeat (30) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_busy", int'(busy), 0);
    check("arst_left", int'(bricks_left), 60);
    query(3, 7, "arst_qry");
    @(negedge clk);
    rst = 1'b0;
    run_scan(405, 97);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
